// File: rtl/sharp_lcd_pkg.sv
// Shared definitions for the Sharp memory-LCD line receiver: FSM encoding,
// mode-byte bit positions and serial field widths.
package sharp_lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_ADDR,
    ST_DATA,
    ST_DUMMY,
    ST_TRAIL
  } state_e;

  localparam int M0_BIT = 0;  // update (write line) command
  localparam int M1_BIT = 1;  // VCOM level
  localparam int M2_BIT = 2;  // clear-all command

  localparam int MODE_BITS         = 8;
  localparam int ADDR_BITS         = 8;
  localparam int DUMMY_BITS        = 8;
  localparam int LINE_BITS_DEFAULT = 144;
  localparam int MAX_ADDR_DEFAULT  = 168;

endpackage

// File: rtl/sharp_sync_edge.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized copy.
module sharp_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sharp_line_receiver.sv
// Receives the Sharp memory-LCD serial protocol and presents each completed
// gate line (address + pixel bits) with a one-cycle valid pulse.
module sharp_line_receiver
  import sharp_lcd_pkg::*;
#(
  parameter int DATA_BITS = LINE_BITS_DEFAULT,
  parameter int MAX_ADDR  = MAX_ADDR_DEFAULT
) (
  input  logic                 clk_12mhz,
  input  logic                 rst,
  input  logic                 SCLK,
  input  logic                 SI,
  input  logic                 SCS,
  output logic                 line_valid,
  output logic [7:0]           line_addr,
  output logic [DATA_BITS-1:0] line_data,
  output logic                 vcom,
  output logic                 clear_all,
  output logic                 frame_err,
  output logic                 addr_err
);

  localparam logic [7:0] BYTE_LAST = 8'(MODE_BITS - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_BITS - 1);
  localparam logic [7:0] ADDR_MAX  = 8'(MAX_ADDR);

  logic sclk_rise, si_sync, scs_sync;
  logic unused_si_rise, unused_scs_rise;

  sharp_sync_edge u_sclk (.clk_i(clk_12mhz), .rst_i(rst), .async_i(SCLK),
                          .sync_o(), .rise_o(sclk_rise));
  sharp_sync_edge u_si   (.clk_i(clk_12mhz), .rst_i(rst), .async_i(SI),
                          .sync_o(si_sync), .rise_o(unused_si_rise));
  sharp_sync_edge u_scs  (.clk_i(clk_12mhz), .rst_i(rst), .async_i(SCS),
                          .sync_o(scs_sync), .rise_o(unused_scs_rise));

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            byte_q, byte_d, byte_next;
  logic [7:0]            addr_q, addr_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [7:0]            line_addr_q, line_addr_d;
  logic [DATA_BITS-1:0]  line_data_q, line_data_d;
  logic                  vcom_q, vcom_d;
  logic                  valid_q, valid_d, clear_q, clear_d;
  logic                  ferr_q, ferr_d, aerr_q, aerr_d;
  logic                  scs_prev_q;
  logic                  scs_rise, scs_fall, sample;

  assign scs_rise = scs_sync & ~scs_prev_q;
  assign scs_fall = ~scs_sync & scs_prev_q;
  // A same-cycle SCS fall forces scs_sync low, so the coincident bit is dropped.
  assign sample   = sclk_rise & scs_sync;
  assign byte_next = {si_sync, byte_q[7:1]};

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      byte_q      <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      line_addr_q <= '0;
      line_data_q <= '0;
      vcom_q      <= 1'b0;
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
      ferr_q      <= 1'b0;
      aerr_q      <= 1'b0;
      scs_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      line_addr_q <= line_addr_d;
      line_data_q <= line_data_d;
      vcom_q      <= vcom_d;
      valid_q     <= valid_d;
      clear_q     <= clear_d;
      ferr_q      <= ferr_d;
      aerr_q      <= aerr_d;
      scs_prev_q  <= scs_sync;
    end
  end

  // NOTE: every signal gets a default before the case so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    line_addr_d = line_addr_q;
    line_data_d = line_data_q;
    vcom_d      = vcom_q;
    valid_d     = 1'b0;
    clear_d     = 1'b0;
    ferr_d      = 1'b0;
    aerr_d      = 1'b0;

    if (scs_fall) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ferr_d  = (state_q inside {ST_MODE, ST_DATA, ST_DUMMY}) && (cnt_q != 8'd0);
    end else begin
      unique case (state_q)
        ST_IDLE: if (scs_rise) begin
          state_d = ST_MODE;
          cnt_d   = '0;
        end
        ST_MODE: if (sample) begin
          byte_d = byte_next;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == BYTE_LAST) begin
            cnt_d  = '0;
            vcom_d = byte_next[M1_BIT];
            if (byte_next[M2_BIT]) begin
              clear_d = 1'b1;
              state_d = ST_TRAIL;
            end else if (byte_next[M0_BIT]) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_TRAIL;
            end
          end
        end
        ST_ADDR: if (sample) begin
          byte_d = byte_next;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == BYTE_LAST) begin
            cnt_d   = '0;
            addr_d  = byte_next;
            state_d = ST_DATA;
          end
        end
        ST_DATA: if (sample) begin
          shift_d = {si_sync, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == DATA_LAST) begin
            cnt_d       = '0;
            line_data_d = shift_d;
            line_addr_d = addr_q;
            valid_d     = 1'b1;
            aerr_d      = (addr_q == 8'd0) || (addr_q > ADDR_MAX);
            state_d     = ST_DUMMY;
          end
        end
        ST_DUMMY: if (sample) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == BYTE_LAST) begin
            cnt_d   = '0;
            state_d = ST_ADDR;
          end
        end
        ST_TRAIL: ;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign line_valid = valid_q;
  assign line_addr  = line_addr_q;
  assign line_data  = line_data_q;
  assign vcom       = vcom_q;
  assign clear_all  = clear_q;
  assign frame_err  = ferr_q;
  assign addr_err   = aerr_q;

endmodule

// File: tb/tb_sharp_line_receiver.sv
// Scoreboard bench: expected pulses are queued as stimulus is driven and
// popped by a monitor when the receiver pulses an output.
`timescale 1ns/1ps
module tb_sharp_line_receiver;

  localparam int DB = 144;
  localparam int MA = 168;

  logic          clk_12mhz = 1'b0;
  logic          rst, SCLK, SI, SCS;
  logic          line_valid, vcom, clear_all, frame_err, addr_err;
  logic [7:0]    line_addr;
  logic [DB-1:0] line_data;

  sharp_line_receiver #(.DATA_BITS(DB), .MAX_ADDR(MA)) dut (
    .clk_12mhz(clk_12mhz), .rst(rst), .SCLK(SCLK), .SI(SI), .SCS(SCS),
    .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data),
    .vcom(vcom), .clear_all(clear_all), .frame_err(frame_err), .addr_err(addr_err)
  );

  always #42 clk_12mhz = ~clk_12mhz;

  typedef enum logic [1:0] {EV_NONE, EV_LINE, EV_CLEAR, EV_FERR} ev_e;
  typedef struct {
    ev_e           kind;
    logic [7:0]    addr;
    logic [DB-1:0] data;
    logic          aerr;
  } ev_t;

  ev_t           sb[$];
  ev_t           mon_e;
  int            n_vec = 0;
  int            n_bad = 0;
  logic [7:0]    exp_addr = '0;
  logic [DB-1:0] exp_data = '0;
  logic          exp_vcom = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_12mhz) begin
    if (!rst) begin
      if (line_valid) begin
        if (sb.size() == 0) check("spurious_line", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("line_kind", EV_LINE, mon_e.kind);
          check("line_addr", line_addr, mon_e.addr);
          check("line_data", line_data, mon_e.data);
          check("addr_err", addr_err, mon_e.aerr);
          exp_addr = mon_e.addr;
          exp_data = mon_e.data;
        end
      end
      if (clear_all) begin
        if (sb.size() == 0) check("spurious_clear", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("clear_kind", EV_CLEAR, mon_e.kind);
        end
      end
      if (frame_err) begin
        if (sb.size() == 0) check("spurious_frame_err", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("ferr_kind", EV_FERR, mon_e.kind);
        end
      end
      if (addr_err && !line_valid) check("addr_err_alone", 1, 0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  task automatic send_bit(input logic b);
    SI = b;
    SCLK = 1'b0;
    wait_clk(4);
    SCLK = 1'b1;
    wait_clk(4);
    SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_mode(input logic [7:0] m);
    if (m[2]) sb.push_back('{EV_CLEAR, 8'd0, '0, 1'b0});
    send_byte(m);
    exp_vcom = m[1];
  endtask

  task automatic send_line(input logic [7:0] a, input logic [DB-1:0] d);
    sb.push_back('{EV_LINE, a, d, (a == 8'd0) || (a > 8'(MA))});
    send_byte(a);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_byte(8'h00);
  endtask

  task automatic cs_on();
    SCS = 1'b1;
    wait_clk(6);
  endtask

  task automatic cs_off();
    wait_clk(6);
    SCS = 1'b0;
    wait_clk(8);
  endtask

  task automatic drain(input string tag);
    wait_clk(4);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  function automatic logic [DB-1:0] rand_line();
    logic [DB-1:0] v;
    for (int i = 0; i < DB; i += 32) v[i +: 16] = 16'($urandom);
    for (int i = 16; i < DB; i += 32) v[i +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {line_valid, clear_all, frame_err, addr_err}, 4'b0);
    check({tag, "_addr"}, line_addr, 8'd0);
    check({tag, "_data"}, line_data, '0);
    check({tag, "_vcom"}, vcom, 1'b0);
  endtask

  logic [DB-1:0] d;

  initial begin
    rst = 1'b1; SCLK = 1'b0; SI = 1'b0; SCS = 1'b0;
    wait_clk(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    // Single update transfer, then 16 zero bits
    cs_on();
    send_mode(8'h01);
    send_line(8'd50, 144'hFFFF_0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    send_byte(8'h00);
    cs_off();
    drain("update_drain");
    check("update_vcom", vcom, exp_vcom);

    // Multi-line with VCOM high
    cs_on();
    send_mode(8'h03);
    send_line(8'd1, rand_line());
    send_line(8'd2, rand_line());
    send_byte(8'h00);
    cs_off();
    drain("multi_drain");
    check("multi_vcom", vcom, exp_vcom);

    // Clear-all
    cs_on();
    send_mode(8'h04);
    send_byte(8'hA5);
    cs_off();
    drain("clear_drain");
    check("clear_vcom", vcom, exp_vcom);

    // SCS drops after 70 data bits
    cs_on();
    send_mode(8'h01);
    send_byte(8'd90);
    d = rand_line();
    for (int i = 0; i < 70; i++) send_bit(d[i]);
    sb.push_back('{EV_FERR, 8'd0, '0, 1'b0});
    cs_off();
    drain("partial_data_drain");
    check("partial_keep_addr", line_addr, exp_addr);
    check("partial_keep_data", line_data, exp_data);

    // Partial mode byte -> frame error; partial address -> silent
    cs_on();
    sb.push_back('{EV_FERR, 8'd0, '0, 1'b0});
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    cs_off();
    drain("partial_mode_drain");
    cs_on();
    send_mode(8'h01);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cs_off();
    drain("partial_addr_drain");

    // Static mode with M1 set, trailer ignored; edges with SCS low ignored
    cs_on();
    send_mode(8'h02);
    send_byte(8'h55);
    cs_off();
    send_byte(8'hFF);
    drain("static_drain");
    check("static_vcom", vcom, exp_vcom);

    // Address boundaries: 0 and 169 flag errors, 168 does not
    cs_on();
    send_mode(8'h01);
    send_line(8'd0, rand_line());
    send_line(8'd169, rand_line());
    send_line(8'd168, rand_line());
    cs_off();
    drain("bounds_drain");

    // Reset mid-transfer, then a clean transfer to address 7
    cs_on();
    send_mode(8'h01);
    send_byte(8'd9);
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    rst = 1'b1;
    SCS = 1'b0;
    SCLK = 1'b0;
    wait_clk(3);
    check_idle_outputs("midrst");
    rst = 1'b0;
    exp_addr = '0; exp_data = '0; exp_vcom = 1'b0;
    wait_clk(4);
    check_idle_outputs("post_rst");
    drain("rst_drain");
    cs_on();
    send_mode(8'h01);
    send_line(8'd7, rand_line());
    cs_off();
    drain("after_rst_drain");
    check("after_rst_addr", line_addr, 8'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
